// File: rtl/ser2par_pkg.sv
// -----------------------------------------------------------------------------
// ser2par_pkg
// Shared types and elaboration-time helpers for the lane deserializer.
//   pack_mode_e      : word packing order latched at the first beat of a word
//   calc_beats       : beats needed to fill one output word
//   calc_count_width : width of a counter that must hold 0..beats inclusive
// -----------------------------------------------------------------------------
package ser2par_pkg;

    typedef enum logic {
        PACK_LSB_FIRST = 1'b0,
        PACK_MSB_FIRST = 1'b1
    } pack_mode_e;

    function automatic int calc_beats(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

    function automatic int calc_count_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/ser2par_out_slot.sv
// -----------------------------------------------------------------------------
// ser2par_out_slot
// One-entry registered valid/ready output holding register.
// Optional feature macro: SER2PAR_PARITY_EN (adds registered even parity).
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   i_load        : load a new word (only asserted while o_slot_free)
//   i_data/i_count: word and its valid-beat count to load
//   i_ready       : consumer accepts the held word
//   o_slot_free   : slot is empty or is being emptied this cycle
//   o_valid/o_data/o_count : held word
//   o_parity      : XOR of o_data (SER2PAR_PARITY_EN only)
// -----------------------------------------------------------------------------
module ser2par_out_slot
    import ser2par_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_load,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_ready,
    output logic                   o_slot_free,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [COUNT_WIDTH-1:0] o_count
`ifdef SER2PAR_PARITY_EN
    ,
    output logic                   o_parity
`endif
);

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [COUNT_WIDTH-1:0] r_count;

    assign o_slot_free = !r_valid || i_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_count     = r_count;

    // Holding register: a load wins over a same-cycle handshake so words stream with no bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_count <= i_count;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

`ifdef SER2PAR_PARITY_EN
    logic r_parity;
    assign o_parity = r_parity;

    // Parity is captured together with the word so it is valid exactly when o_valid is.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_parity <= calc_parity(i_data);
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

endmodule

// File: rtl/ser2par_lane_deser.sv
// -----------------------------------------------------------------------------
// ser2par_lane_deser
// Serial-to-parallel deserializer: LANES bits per beat, DATA_WIDTH-bit words,
// MSB-first or LSB-first packing, partial-word flush, registered output slot.
// Optional feature macro: SER2PAR_PARITY_EN (adds dout_parity output).
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   din/din_valid/din_ready: input beat handshake
//   msb_first              : packing order, sampled at the first beat of a word
//   flush                  : pulse, emit the partial word (ignored when empty)
//   dout/dout_count        : assembled word and number of valid beats in it
//   dout_valid/dout_ready  : output word handshake
//   dout_parity            : XOR of dout (SER2PAR_PARITY_EN only)
// -----------------------------------------------------------------------------
module ser2par_lane_deser
    import ser2par_pkg::*;
#(
    parameter  int DATA_WIDTH  = 16,
    parameter  int LANES       = 1,
    localparam int BEATS       = calc_beats(DATA_WIDTH, LANES),
    localparam int COUNT_WIDTH = calc_count_width(BEATS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [LANES-1:0]       din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   msb_first,
    input  logic                   flush,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [COUNT_WIDTH-1:0] dout_count,
    output logic                   dout_valid,
    input  logic                   dout_ready
`ifdef SER2PAR_PARITY_EN
    ,
    output logic                   dout_parity
`endif
);

    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(BEATS - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(BEATS);

    logic [DATA_WIDTH-1:0]  r_sreg;
    logic [COUNT_WIDTH-1:0] r_cnt;
    pack_mode_e             r_mode;
    logic                   r_flush_pend;

    logic                   w_slot_free;
    logic                   w_fire;
    logic                   w_last;
    logic                   w_discharge;
    logic                   w_flush_arm;
    logic                   w_load;
    pack_mode_e             w_mode;
    logic [DATA_WIDTH-1:0]  w_shifted;
    logic [DATA_WIDTH-1:0]  w_load_data;
    logic [COUNT_WIDTH-1:0] w_load_count;

    // The completing beat is only refused when the output slot cannot take the word.
    assign din_ready    = !r_flush_pend && ((r_cnt != LAST_CNT) || w_slot_free);
    assign w_fire       = din_valid && din_ready;
    assign w_last       = w_fire && (r_cnt == LAST_CNT);
    assign w_discharge  = r_flush_pend && w_slot_free;
    // A flush on an empty word, or one overtaken by the completing beat, is dropped.
    assign w_flush_arm  = flush && (r_cnt != '0) && !w_last;
    // w_last and w_discharge are exclusive: beats are refused while a flush is pending.
    assign w_load       = w_last || w_discharge;
    assign w_load_data  = w_last ? w_shifted : r_sreg;
    assign w_load_count = w_last ? FULL_CNT : r_cnt;

    // Effective packing order and the shift-register value after an accepted beat.
    always_comb begin
        w_mode    = r_mode;
        w_shifted = '0;
        if (r_cnt == '0) begin
            w_mode = pack_mode_e'(msb_first);
        end else begin
            w_mode = r_mode;
        end
        case (w_mode)
            PACK_MSB_FIRST: w_shifted = {r_sreg[DATA_WIDTH-LANES-1:0], din};
            PACK_LSB_FIRST: w_shifted = {din, r_sreg[DATA_WIDTH-1:LANES]};
            default:        w_shifted = '0;
        endcase
    end

    // Word assembly state: shift register, beat counter, mode latch and pending flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_mode       <= PACK_LSB_FIRST;
            r_flush_pend <= 1'b0;
        end else if (w_discharge) begin
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else if (w_fire) begin
            r_mode       <= w_mode;
            r_flush_pend <= w_flush_arm;
            if (w_last) begin
                r_sreg <= '0;
                r_cnt  <= '0;
            end else begin
                r_sreg <= w_shifted;
                r_cnt  <= r_cnt + COUNT_WIDTH'(1);
            end
        end else begin
            r_flush_pend <= r_flush_pend || w_flush_arm;
        end
    end

    ser2par_out_slot #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_out_slot (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_load),
        .i_data      (w_load_data),
        .i_count     (w_load_count),
        .i_ready     (dout_ready),
        .o_slot_free (w_slot_free),
        .o_valid     (dout_valid),
        .o_data      (dout),
        .o_count     (dout_count)
`ifdef SER2PAR_PARITY_EN
        ,
        .o_parity    (dout_parity)
`endif
    );

endmodule

// File: tb/tb_ser2par_lane_deser.sv
// -----------------------------------------------------------------------------
// tb_ser2par_lane_deser
// Two instances: A (DATA_WIDTH=8, LANES=1) and B (DATA_WIDTH=16, LANES=4).
// Directed scenario tasks plus randomized traffic scored against a word-level
// reference model. Honours SER2PAR_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_ser2par_lane_deser;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [0:0]  a_din;
    logic        a_din_valid, a_din_ready, a_msb_first, a_flush;
    logic [7:0]  a_dout;
    logic [3:0]  a_dout_count;
    logic        a_dout_valid, a_dout_ready;
    logic [3:0]  b_din;
    logic        b_din_valid, b_din_ready, b_msb_first, b_flush;
    logic [15:0] b_dout;
    logic [2:0]  b_dout_count;
    logic        b_dout_valid, b_dout_ready;
`ifdef SER2PAR_PARITY_EN
    logic        a_dout_parity, b_dout_parity;
`endif

    always #5 clk = ~clk;

    ser2par_lane_deser #(.DATA_WIDTH(8), .LANES(1)) u_a (
        .clk(clk), .resetn(resetn), .din(a_din), .din_valid(a_din_valid),
        .din_ready(a_din_ready), .msb_first(a_msb_first), .flush(a_flush),
        .dout(a_dout), .dout_count(a_dout_count), .dout_valid(a_dout_valid),
        .dout_ready(a_dout_ready)
`ifdef SER2PAR_PARITY_EN
        , .dout_parity(a_dout_parity)
`endif
    );

    ser2par_lane_deser #(.DATA_WIDTH(16), .LANES(4)) u_b (
        .clk(clk), .resetn(resetn), .din(b_din), .din_valid(b_din_valid),
        .din_ready(b_din_ready), .msb_first(b_msb_first), .flush(b_flush),
        .dout(b_dout), .dout_count(b_dout_count), .dout_valid(b_dout_valid),
        .dout_ready(b_dout_ready)
`ifdef SER2PAR_PARITY_EN
        , .dout_parity(b_dout_parity)
`endif
    );

    // Word value from the list of beats received so far: MSB-first puts the
    // first beat highest among the filled beats; LSB-first puts the last beat
    // at the top of the word and leaves the unfilled beats at the bottom.
    function automatic logic [15:0] pack_word(input int beats[$], input bit msb,
                                              input int nbeats, input int lanes);
        logic [15:0] w;
        int k;
        w = 16'h0000;
        k = beats.size();
        for (int i = 0; i < k; i++) begin
            if (msb) w = w | (16'(beats[i]) << (lanes * (k - 1 - i)));
            else     w = w | (16'(beats[i]) << (lanes * (nbeats - k + i)));
        end
        return w;
    endfunction

    // ---------------- reference model / scoreboard, instance A ----------------
    int         a_beats[$];
    bit         a_mode, a_pend, a_hold, a_take;
    logic [7:0] a_hold_data, a_e_data;
    int         a_e_cnt;
    logic [7:0] a_exp_data[$];
    int         a_exp_cnt[$];

    always @(negedge clk) begin
        if (!resetn) begin
            a_beats.delete(); a_exp_data.delete(); a_exp_cnt.delete();
            a_pend = 1'b0; a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                n_checks++;
                if (a_dout_valid !== 1'b1 || a_dout !== a_hold_data) begin
                    n_fail++;
                    $display("FAIL a_hold_stable: dout=%h valid=%b, required dout=%h valid=1", a_dout, a_dout_valid, a_hold_data);
                end
            end
            if (a_dout_valid && a_dout_ready) begin
                n_checks++;
                if (a_exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_unexpected_word: dout=%h count=%0d, required no word", a_dout, a_dout_count);
                end else begin
                    a_e_data = a_exp_data.pop_front();
                    a_e_cnt  = a_exp_cnt.pop_front();
                    if (a_dout !== a_e_data || a_dout_count !== 4'(a_e_cnt)) begin
                        n_fail++;
                        $display("FAIL a_word: dout=%h count=%0d, required dout=%h count=%0d", a_dout, a_dout_count, a_e_data, a_e_cnt);
                    end
`ifdef SER2PAR_PARITY_EN
                    n_checks++;
                    if (a_dout_parity !== ^a_e_data) begin
                        n_fail++;
                        $display("FAIL a_parity: parity=%b, required %b", a_dout_parity, ^a_e_data);
                    end
`endif
                end
            end
            a_hold      = a_dout_valid && !a_dout_ready;
            a_hold_data = a_dout;
            a_take      = a_flush && !a_pend && (a_beats.size() > 0);
            if (a_din_valid && a_din_ready) begin
                n_checks++;
                if (a_pend) begin
                    n_fail++;
                    $display("FAIL a_beat_during_flush: din_ready=1, required 0");
                end
                if (a_beats.size() == 0) a_mode = a_msb_first;
                a_beats.push_back(int'(a_din));
                if (a_beats.size() == 8) begin
                    a_exp_data.push_back(8'(pack_word(a_beats, a_mode, 8, 1)));
                    a_exp_cnt.push_back(8);
                    a_beats.delete();
                    a_take = 1'b0;
                end
            end
            if (a_pend && (!a_dout_valid || a_dout_ready)) a_pend = 1'b0;
            if (a_take) begin
                a_exp_data.push_back(8'(pack_word(a_beats, a_mode, 8, 1)));
                a_exp_cnt.push_back(a_beats.size());
                a_beats.delete();
                a_pend = 1'b1;
            end
        end
    end

    // ---------------- reference model / scoreboard, instance B ----------------
    int          b_beats[$];
    bit          b_mode, b_pend, b_hold, b_take;
    logic [15:0] b_hold_data, b_e_data;
    int          b_e_cnt;
    logic [15:0] b_exp_data[$];
    int          b_exp_cnt[$];

    always @(negedge clk) begin
        if (!resetn) begin
            b_beats.delete(); b_exp_data.delete(); b_exp_cnt.delete();
            b_pend = 1'b0; b_hold = 1'b0;
        end else begin
            if (b_hold) begin
                n_checks++;
                if (b_dout_valid !== 1'b1 || b_dout !== b_hold_data) begin
                    n_fail++;
                    $display("FAIL b_hold_stable: dout=%h valid=%b, required dout=%h valid=1", b_dout, b_dout_valid, b_hold_data);
                end
            end
            if (b_dout_valid && b_dout_ready) begin
                n_checks++;
                if (b_exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_unexpected_word: dout=%h count=%0d, required no word", b_dout, b_dout_count);
                end else begin
                    b_e_data = b_exp_data.pop_front();
                    b_e_cnt  = b_exp_cnt.pop_front();
                    if (b_dout !== b_e_data || b_dout_count !== 3'(b_e_cnt)) begin
                        n_fail++;
                        $display("FAIL b_word: dout=%h count=%0d, required dout=%h count=%0d", b_dout, b_dout_count, b_e_data, b_e_cnt);
                    end
`ifdef SER2PAR_PARITY_EN
                    n_checks++;
                    if (b_dout_parity !== ^b_e_data) begin
                        n_fail++;
                        $display("FAIL b_parity: parity=%b, required %b", b_dout_parity, ^b_e_data);
                    end
`endif
                end
            end
            b_hold      = b_dout_valid && !b_dout_ready;
            b_hold_data = b_dout;
            b_take      = b_flush && !b_pend && (b_beats.size() > 0);
            if (b_din_valid && b_din_ready) begin
                n_checks++;
                if (b_pend) begin
                    n_fail++;
                    $display("FAIL b_beat_during_flush: din_ready=1, required 0");
                end
                if (b_beats.size() == 0) b_mode = b_msb_first;
                b_beats.push_back(int'(b_din));
                if (b_beats.size() == 4) begin
                    b_exp_data.push_back(pack_word(b_beats, b_mode, 4, 4));
                    b_exp_cnt.push_back(4);
                    b_beats.delete();
                    b_take = 1'b0;
                end
            end
            if (b_pend && (!b_dout_valid || b_dout_ready)) b_pend = 1'b0;
            if (b_take) begin
                b_exp_data.push_back(pack_word(b_beats, b_mode, 4, 4));
                b_exp_cnt.push_back(b_beats.size());
                b_beats.delete();
                b_pend = 1'b1;
            end
        end
    end

    // Present one beat to instance A and wait (bounded) until it is accepted.
    task automatic a_send(input logic b);
        int  n;
        bit  acc;
        n = 0; acc = 1'b0;
        a_din = b; a_din_valid = 1'b1;
        while (!acc) begin
            @(negedge clk); acc = a_din_ready;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 50) begin
                n_checks++; n_fail++;
                $display("FAIL a_send_timeout: din_ready=0 for %0d cycles, required acceptance", n);
                acc = 1'b1;
            end
        end
        a_din_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 8;
        if (a_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: %b, required 0", a_dout_valid); end
        if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_a_dout: %h, required 00", a_dout); end
        if (a_dout_count !== 4'd0) begin n_fail++; $display("FAIL reset_a_count: %0d, required 0", a_dout_count); end
        if (a_din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: %b, required 1", a_din_ready); end
        if (b_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: %b, required 0", b_dout_valid); end
        if (b_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_b_dout: %h, required 0000", b_dout); end
        if (b_dout_count !== 3'd0) begin n_fail++; $display("FAIL reset_b_count: %0d, required 0", b_dout_count); end
        if (b_din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: %b, required 1", b_din_ready); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hB2;
        a_dout_ready = 1'b1; a_msb_first = 1'b1;
        for (int i = 7; i >= 0; i--) a_send(w[i]);
        n_checks++;
        if (a_dout_valid !== 1'b1 || a_dout !== 8'hB2 || a_dout_count !== 4'd8) begin
            n_fail++;
            $display("FAIL msb_word: valid=%b dout=%h count=%0d, required 1 b2 8", a_dout_valid, a_dout, a_dout_count);
        end
`ifdef SER2PAR_PARITY_EN
        n_checks++;
        if (a_dout_parity !== 1'b0) begin n_fail++; $display("FAIL msb_parity: %b, required 0", a_dout_parity); end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (a_dout_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_one_cycle: %b, required 0", a_dout_valid); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'hB2;
        a_msb_first = 1'b0;
        for (int i = 7; i >= 0; i--) a_send(w[i]);
        n_checks++;
        if (a_dout_valid !== 1'b1 || a_dout !== 8'h4D || a_dout_count !== 4'd8) begin
            n_fail++;
            $display("FAIL lsb_word: valid=%b dout=%h count=%0d, required 1 4d 8", a_dout_valid, a_dout, a_dout_count);
        end
`ifdef SER2PAR_PARITY_EN
        n_checks++;
        if (a_dout_parity !== 1'b0) begin n_fail++; $display("FAIL lsb_parity: %b, required 0", a_dout_parity); end
`endif
        // mode toggled after the first beat must not affect the word
        for (int i = 7; i >= 0; i--) begin
            a_msb_first = (i == 7);
            a_send(w[i]);
        end
        n_checks++;
        if (a_dout_valid !== 1'b1 || a_dout !== 8'hB2) begin
            n_fail++;
            $display("FAIL mode_latched: valid=%b dout=%h, required 1 b2", a_dout_valid, a_dout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lanes4();
        logic [31:0] nib;
        nib = 32'hABCD1234;
        b_dout_ready = 1'b1; b_msb_first = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            b_din = nib[4*i +: 4]; b_din_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (b_din_ready !== 1'b1) begin n_fail++; $display("FAIL lanes4_no_bubble: din_ready=%b at beat %0d, required 1", b_din_ready, 7 - i); end
            @(posedge clk); #1;
            if (i == 4 || i == 0) begin
                n_checks++;
                if (b_dout_valid !== 1'b1 || b_dout !== ((i == 4) ? 16'hABCD : 16'h1234) || b_dout_count !== 3'd4) begin
                    n_fail++;
                    $display("FAIL lanes4_word: valid=%b dout=%h count=%0d, required 1 %h 4", b_dout_valid, b_dout, b_dout_count, (i == 4) ? 16'hABCD : 16'h1234);
                end
            end
        end
        b_din_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] w1, w2;
        w1 = 8'($urandom); w2 = 8'($urandom);
        a_dout_ready = 1'b0; a_msb_first = 1'b1;
        for (int i = 7; i >= 0; i--) a_send(w1[i]);
        for (int i = 7; i >= 1; i--) begin
            a_din = w2[i]; a_din_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (a_din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: din_ready=%b, required 1", a_din_ready); end
            @(posedge clk); #1;
        end
        a_din = w2[0]; a_din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (a_din_ready !== 1'b0 || a_dout !== w1 || a_dout_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall: din_ready=%b dout=%h valid=%b, required 0 %h 1", a_din_ready, a_dout, a_dout_valid, w1);
            end
            @(posedge clk); #1;
        end
        a_dout_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: din_ready=%b, required 1", a_din_ready); end
        @(posedge clk); #1;
        a_din_valid = 1'b0; a_dout_ready = 1'b0;
        n_checks++;
        if (a_dout_valid !== 1'b1 || a_dout !== w2 || a_dout_count !== 4'd8) begin
            n_fail++;
            $display("FAIL bp_second_word: valid=%b dout=%h count=%0d, required 1 %h 8", a_dout_valid, a_dout, a_dout_count, w2);
        end
        a_dout_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [7:0] w;
        a_dout_ready = 1'b1;
        for (int m = 1; m >= 0; m--) begin
            a_msb_first = m[0];
            a_send(1'b1); a_send(1'b1); a_send(1'b0);
            a_flush = 1'b1;
            @(posedge clk); #1;
            a_flush = 1'b0;
            n_checks++;
            if (a_dout_valid !== 1'b0 || a_din_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_pending: valid=%b din_ready=%b, required 0 0", a_dout_valid, a_din_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (a_dout_valid !== 1'b1 || a_dout !== ((m == 1) ? 8'h06 : 8'h60) || a_dout_count !== 4'd3) begin
                n_fail++;
                $display("FAIL flush_word: valid=%b dout=%h count=%0d, required 1 %h 3", a_dout_valid, a_dout, a_dout_count, (m == 1) ? 8'h06 : 8'h60);
            end
            @(posedge clk); #1;
        end
        // flush with an empty word
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_dout_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: valid=%b, required 0", a_dout_valid); end
        // flush together with the completing beat
        w = 8'hC5; a_msb_first = 1'b1;
        for (int i = 7; i >= 1; i--) a_send(w[i]);
        a_din = w[0]; a_din_valid = 1'b1; a_flush = 1'b1;
        @(posedge clk); #1;
        a_din_valid = 1'b0; a_flush = 1'b0;
        n_checks++;
        if (a_dout_valid !== 1'b1 || a_dout !== 8'hC5 || a_dout_count !== 4'd8) begin
            n_fail++;
            $display("FAIL flush_last_beat: valid=%b dout=%h count=%0d, required 1 c5 8", a_dout_valid, a_dout, a_dout_count);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_dout_valid !== 1'b0 || a_din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_last_no_extra: valid=%b din_ready=%b, required 0 1", a_dout_valid, a_din_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'($urandom);
        a_dout_ready = 1'b0; a_msb_first = 1'b1;
        for (int i = 7; i >= 0; i--) a_send(w[i]);
        for (int i = 0; i < 5; i++) a_send(1'($urandom));
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (a_dout_valid !== 1'b0 || a_dout !== 8'h00 || a_din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b dout=%h din_ready=%b, required 0 00 1", a_dout_valid, a_dout, a_din_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        a_dout_ready = 1'b1;
        w = 8'h07;
        for (int i = 7; i >= 0; i--) a_send(w[i]);
        n_checks++;
        if (a_dout_valid !== 1'b1 || a_dout !== 8'h07 || a_dout_count !== 4'd8) begin
            n_fail++;
            $display("FAIL reset_clean_word: valid=%b dout=%h count=%0d, required 1 07 8", a_dout_valid, a_dout, a_dout_count);
        end
`ifdef SER2PAR_PARITY_EN
        n_checks++;
        if (a_dout_parity !== 1'b1) begin n_fail++; $display("FAIL reset_parity: %b, required 1", a_dout_parity); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            a_din = 1'($urandom); a_din_valid = ($urandom_range(0, 3) != 0);
            a_msb_first = 1'($urandom); a_flush = ($urandom_range(0, 15) == 0);
            a_dout_ready = ($urandom_range(0, 2) != 0);
            b_din = 4'($urandom); b_din_valid = ($urandom_range(0, 3) != 0);
            b_msb_first = 1'($urandom); b_flush = ($urandom_range(0, 11) == 0);
            b_dout_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        a_din_valid = 1'b0; a_flush = 1'b0; a_dout_ready = 1'b1;
        b_din_valid = 1'b0; b_flush = 1'b0; b_dout_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (a_exp_data.size() != 0 || b_exp_data.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: words outstanding a=%0d b=%0d, required 0 0", a_exp_data.size(), b_exp_data.size());
        end
    endtask

    initial begin
        a_din = 1'b0; a_din_valid = 1'b0; a_msb_first = 1'b1; a_flush = 1'b0; a_dout_ready = 1'b1;
        b_din = 4'h0; b_din_valid = 1'b0; b_msb_first = 1'b1; b_flush = 1'b0; b_dout_ready = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_lanes4();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
